// File: rtl/lfsr_arbiter.sv
// Four-requester arbiter with pseudo-random search start taken from a free-running
// 4-bit maximal-length LFSR, and a bounded grant tenure.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; any nonzero req_i is granted at the next edge
// GRANT | owner held in gnt_id_q; released on owner drop or hold timeout
module lfsr_arbiter #(
    parameter logic [3:0] SEED     = 4'b1000,
    parameter int         HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_id_o,
    output logic       busy_o,
    output logic [3:0] lfsr_o
);

    // An all-zero seed would lock the LFSR, so it is replaced by 0001.
    localparam logic [3:0] SEED_EFF  = (SEED == 4'b0000) ? 4'b0001 : SEED;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [3:0] lfsr_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic       busy_q;
    logic [7:0] hold_q;

    logic [1:0] search_start;
    logic [1:0] cand;
    logic [1:0] pick_id;
    logic       pick_found;
    logic       owner_req;
    logic       hold_done;

    assign search_start = lfsr_q[1:0];
    assign owner_req    = req_i[gnt_id_q];
    assign hold_done    = (hold_q == HOLD_LAST);

    // Rotating search: first requester at or after search_start, wrapping mod 4.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = 2'd0;
        cand       = search_start;
        for (int k = 0; k < 4; k++) begin
            cand = search_start + 2'(k);
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q   <= SEED_EFF;
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            busy_q   <= 1'b0;
            hold_q   <= 8'd0;
        end else begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q  <= GRANT;
                        gnt_q    <= 4'b0001 << pick_id;
                        gnt_id_q <= pick_id;
                        busy_q   <= 1'b1;
                        hold_q   <= 8'd0;
                    end
                end
                GRANT: begin
                    // Owner drop and timeout on the same edge both end in IDLE.
                    if (!owner_req || hold_done) begin
                        state_q  <= IDLE;
                        gnt_q    <= 4'b0000;
                        gnt_id_q <= 2'd0;
                        busy_q   <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    gnt_q    <= 4'b0000;
                    gnt_id_q <= 2'd0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = gnt_id_q;
    assign busy_o   = busy_q;
    assign lfsr_o   = lfsr_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Bench for lfsr_arbiter: two builds (default seed/hold, and SEED=0 with HOLD_MAX=3)
// driven in lockstep and compared every cycle against a tenure-level model.
module tb_lfsr_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt0, gnt1, lfsr0, lfsr1;
    logic [1:0] id0, id1;
    logic       busy0, busy1;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    lfsr_arbiter #(.SEED(4'b1000), .HOLD_MAX(8)) dut0 (
        .clk(clk), .reset(reset), .req_i(req),
        .gnt_o(gnt0), .gnt_id_o(id0), .busy_o(busy0), .lfsr_o(lfsr0)
    );

    lfsr_arbiter #(.SEED(4'b0000), .HOLD_MAX(3)) dut1 (
        .clk(clk), .reset(reset), .req_i(req),
        .gnt_o(gnt1), .gnt_id_o(id1), .busy_o(busy1), .lfsr_o(lfsr1)
    );

    // Full LFSR orbit starting at 1000; the model walks this table by index.
    logic [3:0] seq [15] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001,
                             4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
                             4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};

    int seed_idx [2] = '{0, 1};
    int hold_max [2] = '{8, 3};
    int m_idx    [2];
    int m_owner  [2];
    int m_cnt    [2];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks owner and number of grant cycles already given in this tenure.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_idx[i]   = seed_idx[i];
                m_owner[i] = -1;
                m_cnt[i]   = 0;
            end else begin
                if (m_owner[i] < 0) begin
                    if (req != 4'b0000) begin
                        for (int k = 0; k < 4; k++) begin
                            int c;
                            c = (int'(seq[m_idx[i]] % 4) + k) % 4;
                            if (m_owner[i] < 0 && req[c]) m_owner[i] = c;
                        end
                        m_cnt[i] = 1;
                    end
                end else if (!req[m_owner[i]] || m_cnt[i] == hold_max[i]) begin
                    m_owner[i] = -1;
                end else begin
                    m_cnt[i]++;
                end
                m_idx[i] = (m_idx[i] + 1) % 15;
            end
        end
    end

    task automatic cmp_dut(input int i, input logic [3:0] g, input logic [1:0] id,
                           input logic b, input logic [3:0] l);
        logic [3:0] eg;
        logic [1:0] eid;
        eg  = (m_owner[i] < 0) ? 4'b0000 : (4'b0001 << m_owner[i]);
        eid = (m_owner[i] < 0) ? 2'd0 : 2'(m_owner[i]);
        check($sformatf("dut%0d_gnt", i), {4'b0, g}, {4'b0, eg});
        check($sformatf("dut%0d_gnt_id", i), {6'b0, id}, {6'b0, eid});
        check($sformatf("dut%0d_busy", i), {7'b0, b}, {7'b0, (m_owner[i] >= 0)});
        check($sformatf("dut%0d_lfsr", i), {4'b0, l}, {4'b0, seq[m_idx[i]]});
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_dut(0, gnt0, id0, busy0, lfsr0);
            cmp_dut(1, gnt1, id1, busy1, lfsr1);
        end
    end

    task automatic wait_lfsr0(input logic [3:0] target);
        int n;
        n = 0;
        while (seq[m_idx[0]] != target && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_lfsr0_bound", {4'b0, seq[m_idx[0]]}, {4'b0, target});
    endtask

    initial begin
        @(posedge clk);
        #1 cmp_en = 1'b1;
        @(negedge clk);
        check("reset_gnt0", {4'b0, gnt0}, 8'h00);
        check("reset_busy0", {7'b0, busy0}, 8'h00);
        check("reset_lfsr0", {4'b0, lfsr0}, 8'h08);
        check("reset_lfsr1_seed0", {4'b0, lfsr1}, 8'h01);

        // First post-reset cycle: s=0 for dut0, s=1 for dut1.
        reset = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        check("first_gnt0", {4'b0, gnt0}, 8'h01);
        check("first_id0", {6'b0, id0}, 8'h00);
        check("first_busy0", {7'b0, busy0}, 8'h01);
        check("first_gnt1", {4'b0, gnt1}, 8'h02);

        reset = 1'b0;
        @(negedge clk);
        check("midreset_gnt0", {4'b0, gnt0}, 8'h00);
        check("midreset_busy0", {7'b0, busy0}, 8'h00);
        check("midreset_lfsr0", {4'b0, lfsr0}, 8'h08);
        check("midreset_lfsr1", {4'b0, lfsr1}, 8'h01);

        reset = 1'b1;
        req = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            check("lfsr_seq", {4'b0, lfsr0}, {4'b0, seq[k % 15]});
            check("lfsr_seq_gnt", {4'b0, gnt0}, 8'h00);
            @(negedge clk);
        end

        wait_lfsr0(4'b0010);
        req = 4'b1011;
        @(negedge clk);
        check("wrap_s2", {4'b0, gnt0}, 8'h08);
        req = 4'b0000;
        @(negedge clk);
        wait_lfsr0(4'b0111);
        req = 4'b1011;
        @(negedge clk);
        check("wrap_s3", {4'b0, gnt0}, 8'h08);
        req = 4'b0000;
        @(negedge clk);
        wait_lfsr0(4'b0100);
        req = 4'b1011;
        @(negedge clk);
        check("wrap_s0", {4'b0, gnt0}, 8'h01);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Constant request: dut0 is high 8 of every 9 cycles, dut1 3 of every 4.
        req = 4'b0100;
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            check("timeout_gnt0", {4'b0, gnt0}, ((c % 9) < 8) ? 8'h04 : 8'h00);
            check("timeout_gnt1", {4'b0, gnt1}, ((c % 4) < 3) ? 8'h04 : 8'h00);
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);

        req = 4'b0010;
        @(negedge clk);
        check("early_grant1", {4'b0, gnt0}, 8'h02);
        req = 4'b1010;
        repeat (2) @(negedge clk);
        check("early_hold1", {4'b0, gnt0}, 8'h02);
        req = 4'b1000;
        @(negedge clk);
        check("early_release", {4'b0, gnt0}, 8'h00);
        @(negedge clk);
        check("early_next_owner", {4'b0, gnt0}, 8'h08);

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(63) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
            @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_arbiter.md
# lfsr_arbiter

Four-requester arbiter that shares a single downstream resource using pseudo-random starting priority. An embedded free-running 4-bit maximal-length LFSR selects the search start point, so no requester is starved by fixed priority. A hold-timeout bounds tenure. The block sits between request sources and the resource port it guards. The LFSR state is exported for debug and for bench reference modelling.

## Interface
- `SEED`, default 4'b1000: LFSR value loaded in reset; must be nonzero (4'b0000 is replaced by 4'b0001).
- `HOLD_MAX`, default 8: maximum consecutive grant cycles per tenure; legal range 2..255.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `req_i` in 4: level requests, bit n = requester n.
- `gnt_o` out 4: registered one-hot grant, or all zero.
- `gnt_id_o` out 2: encoded index of the granted requester; 0 when `gnt_o` is zero.
- `busy_o` out 1: high while in GRANT state (equals `|gnt_o`).
- `lfsr_o` out 4: current LFSR state.

## Operation
- LFSR: `lfsr_q` is 4 bits, with polynomial x^4+x^3+1. Next value = {lfsr_q[2:0], lfsr_q[3]^lfsr_q[2]}. Period is 15 and it never reaches zero. It advances every cycle while `reset` is high, independent of arbitration.
- FSM states: IDLE and GRANT.
- IDLE:
  - If `req_i` is nonzero, compute start index s = lfsr_q[1:0].
  - Search indices s, s+1, s+2, s+3 (mod 4) and pick the first with `req_i` set.
  - Register the grant and go to GRANT.
  - If `req_i` == 0, stay in IDLE with `gnt_o` = 0.
- GRANT:
  - Owner index is held in a register. Other requests are ignored.
  - If the owner's `req_i` bit is low: drop the grant and go to IDLE.
  - Else if the hold count equals HOLD_MAX-1: force release (drop the grant, go to IDLE).
  - Else: increment the hold count and keep the grant.
- Hold counter: 8 bits. Cleared on every IDLE->GRANT transition. Counts grant cycles.
- IDLE always lasts at least one cycle between tenures, including after a forced release. A timed-out requester still holding `req_i` re-competes normally.
- Arithmetic: index wrap is modulo 4 (2-bit add, carry discarded).
- Reset values: `lfsr_q` = SEED (or 4'b0001 if SEED is 0), state IDLE, `gnt_o` = 0, `gnt_id_o` = 0, `busy_o` = 0, hold count = 0.

## Timing
- Grant latency: `req_i` sampled at edge n in IDLE, so `gnt_o` is valid after edge n (visible during cycle n+1).
- Release latency: owner `req_i` low at edge m, so `gnt_o` = 0 after edge m. The earliest next grant follows edge m+1.
- Timeout: with continuous owner request, `gnt_o` is high for exactly HOLD_MAX cycles, then low for at least 1 cycle.
- Priority uses the `lfsr_q` value present at the sampling edge, not the post-edge value.
- First cycle after reset deasserts: `lfsr_o` = SEED. The LFSR updates at the following edge.
- Reset mid-grant: `reset` low at any edge forces all outputs to reset values after that edge, regardless of `req_i`.
- Simultaneous owner drop and timeout on the same edge: treated as release. The outcome is identical (IDLE, grant low).
- `req_i` changing in IDLE with no edge has no effect. All outputs are registered, with no combinational path from `req_i` to `gnt_o`.

## Test plan
- Reset, then `req_i` = 4'b1111 from the first post-reset cycle, with `lfsr_o` = 1000 (s=0) -> `gnt_o` = 0001, `gnt_id_o` = 0 one cycle later, `busy_o` = 1.
- LFSR sequence with `req_i` = 0 -> `lfsr_o` = 1000, 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, then 1000 again (period 15). Grants stay 0 throughout.
- Wrap search: raise `req_i` = 4'b1011 when `lfsr_o` = 0010 (s=2) -> `gnt_o` = 1000. Raise it when `lfsr_o` = 0111 (s=3) -> `gnt_o` = 1000. Raise it when `lfsr_o` = 0100 (s=0) -> `gnt_o` = 0001.
- Timeout, HOLD_MAX = 8: `req_i` = 0100 held constant -> `gnt_o` = 0100 for exactly 8 cycles, 0 for 1 cycle, then 0100 again. The pattern repeats.
- Early release: grant to requester 1, then drop `req_i`[1] after 3 grant cycles while `req_i`[3] = 1 -> `gnt_o` goes 0 the next cycle, then 1000 the cycle after.
- Reset mid-tenure: assert `reset` = 0 for one edge during a grant -> `gnt_o` = 0, `busy_o` = 0, `lfsr_o` = SEED. Normal arbitration resumes after release. A SEED = 0 build shows `lfsr_o` = 0001.
